// File: rtl/mem_cmd_gen.sv
// Avalon-MM traffic command generator: issues single write/read commands with
// fixed, incrementing or LFSR addresses and fixed or LFSR write data.
//
// state | meaning
// IDLE  | waiting for a write or read request
// WRITE | write strobe asserted, held while waitrequest is high
// READ  | read strobe asserted, held while waitrequest is high
// GAP   | one-cycle spacer after acceptance, ready pulse is high here
module mem_cmd_gen #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic [1:0]          addr_mode_i,
    input  logic                data_mode_i,
    input  logic [ADDR_W-1:0]   base_addr_i,
    input  logic [DATA_W-1:0]   pattern_i,
    input  logic                wr_en_i,
    input  logic                rd_en_i,
    output logic                cmd_block_ready_o,
    output logic [ADDR_W-1:0]   amm_address_o,
    output logic                amm_write_o,
    output logic                amm_read_o,
    output logic [DATA_W-1:0]   amm_writedata_o,
    output logic [DATA_W/8-1:0] amm_byteenable_o,
    input  logic                amm_waitrequest_i
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] READ  = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    localparam logic [1:0] AM_INC  = 2'b01;
    localparam logic [1:0] AM_RAND = 2'b10;

    logic [1:0]        state;
    logic [1:0]        addr_mode_q;
    logic              data_mode_q;
    logic [ADDR_W-1:0] addr_cnt_q;
    logic [ADDR_W-1:0] addr_lfsr_q;
    logic [DATA_W-1:0] data_pat_q;
    logic [DATA_W-1:0] data_lfsr_q;

    logic              load_now;
    logic              accepted;
    logic [1:0]        addr_mode_eff;
    logic              data_mode_eff;
    logic [ADDR_W-1:0] addr_cnt_eff;
    logic [ADDR_W-1:0] addr_lfsr_eff;
    logic [DATA_W-1:0] data_pat_eff;
    logic [DATA_W-1:0] data_lfsr_eff;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_data;

    // x^24+x^23+x^22+x^17+1, shifting toward the MSB
    function automatic logic [ADDR_W-1:0] addr_lfsr_next(input logic [ADDR_W-1:0] v);
        return {v[ADDR_W-2:0], v[23] ^ v[22] ^ v[21] ^ v[16]};
    endfunction

    // x^32+x^22+x^2+x^1+1, shifting toward the MSB
    function automatic logic [DATA_W-1:0] data_lfsr_next(input logic [DATA_W-1:0] v);
        return {v[DATA_W-2:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    endfunction

    assign amm_byteenable_o = '1;

    // A load in IDLE is forwarded so a coincident request already uses the new seeds
    always_comb begin
        load_now      = load_i && (state == IDLE);
        addr_mode_eff = addr_mode_q;
        data_mode_eff = data_mode_q;
        addr_cnt_eff  = addr_cnt_q;
        addr_lfsr_eff = addr_lfsr_q;
        data_pat_eff  = data_pat_q;
        data_lfsr_eff = data_lfsr_q;
        if (load_now) begin
            addr_mode_eff = addr_mode_i;
            data_mode_eff = data_mode_i;
            addr_cnt_eff  = base_addr_i;
            addr_lfsr_eff = (base_addr_i == '0) ? ADDR_W'(1) : base_addr_i;
            data_pat_eff  = pattern_i;
            data_lfsr_eff = (pattern_i == '0) ? DATA_W'(1) : pattern_i;
        end
        cur_addr = (addr_mode_eff == AM_RAND) ? addr_lfsr_eff : addr_cnt_eff;
        cur_data = data_mode_eff ? data_lfsr_eff : data_pat_eff;
        accepted = (amm_write_o || amm_read_o) && !amm_waitrequest_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state             <= IDLE;
            amm_write_o       <= 1'b0;
            amm_read_o        <= 1'b0;
            cmd_block_ready_o <= 1'b0;
            amm_address_o     <= '0;
            amm_writedata_o   <= '0;
            addr_mode_q       <= 2'b00;
            data_mode_q       <= 1'b0;
            addr_cnt_q        <= '0;
            addr_lfsr_q       <= ADDR_W'(1);
            data_pat_q        <= '0;
            data_lfsr_q       <= DATA_W'(1);
        end else begin
            cmd_block_ready_o <= 1'b0;
            if (load_now) begin
                addr_mode_q <= addr_mode_eff;
                data_mode_q <= data_mode_eff;
                addr_cnt_q  <= addr_cnt_eff;
                addr_lfsr_q <= addr_lfsr_eff;
                data_pat_q  <= data_pat_eff;
                data_lfsr_q <= data_lfsr_eff;
            end
            case (state)
                IDLE: begin
                    if (wr_en_i) begin
                        state           <= WRITE;
                        amm_write_o     <= 1'b1;
                        amm_address_o   <= cur_addr;
                        amm_writedata_o <= cur_data;
                    end else if (rd_en_i) begin
                        state         <= READ;
                        amm_read_o    <= 1'b1;
                        amm_address_o <= cur_addr;
                    end
                end
                WRITE, READ: begin
                    if (accepted) begin
                        state             <= GAP;
                        amm_write_o       <= 1'b0;
                        amm_read_o        <= 1'b0;
                        cmd_block_ready_o <= 1'b1;
                        if (addr_mode_q == AM_INC)
                            addr_cnt_q <= addr_cnt_q + ADDR_W'(1);
                        if (addr_mode_q == AM_RAND)
                            addr_lfsr_q <= addr_lfsr_next(addr_lfsr_q);
                        if ((state == WRITE) && data_mode_q)
                            data_lfsr_q <= data_lfsr_next(data_lfsr_q);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_cmd_gen.sv
// Scoreboard bench for mem_cmd_gen: expected commands are queued when requests
// are driven and compared as the memory side accepts them.
module tb_mem_cmd_gen;
    localparam int AW = 24;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [1:0]    addr_mode;
    logic          data_mode;
    logic [AW-1:0] base_addr;
    logic [DW-1:0] pattern;
    logic          wr_en;
    logic          rd_en;
    logic          ready;
    logic [AW-1:0] address;
    logic          wr;
    logic          rd;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] be;
    logic          waitreq;

    mem_cmd_gen #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk), .rst_i(rst), .load_i(load),
        .addr_mode_i(addr_mode), .data_mode_i(data_mode),
        .base_addr_i(base_addr), .pattern_i(pattern),
        .wr_en_i(wr_en), .rd_en_i(rd_en),
        .cmd_block_ready_o(ready),
        .amm_address_o(address), .amm_write_o(wr), .amm_read_o(rd),
        .amm_writedata_o(wdata), .amm_byteenable_o(be),
        .amm_waitrequest_i(waitreq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   ready_cnt = 0;
    int   ready_cyc[$];
    logic acc_prev = 1'b0;
    logic mon_acc;

    // reference generator state
    logic [1:0]    m_amode;
    logic          m_dmode;
    logic [AW-1:0] m_base;
    logic [AW-1:0] m_alfsr;
    logic [DW-1:0] m_pat;
    logic [DW-1:0] m_dlfsr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [AW-1:0] lfsr24_step(input logic [AW-1:0] v);
        int   taps[4];
        logic fb;
        taps = '{24, 23, 22, 17};
        fb = 1'b0;
        foreach (taps[i]) fb = fb ^ v[taps[i]-1];
        return {v[AW-2:0], fb};
    endfunction

    function automatic logic [DW-1:0] lfsr32_step(input logic [DW-1:0] v);
        int   taps[4];
        logic fb;
        taps = '{32, 22, 2, 1};
        fb = 1'b0;
        foreach (taps[i]) fb = fb ^ v[taps[i]-1];
        return {v[DW-2:0], fb};
    endfunction

    task automatic model_reset();
        m_amode = 2'b00; m_dmode = 1'b0;
        m_base = '0; m_alfsr = AW'(1);
        m_pat = '0; m_dlfsr = DW'(1);
    endtask

    task automatic model_load(input logic [1:0] am, input logic dm,
                              input logic [AW-1:0] b, input logic [DW-1:0] p);
        m_amode = am; m_dmode = dm;
        m_base  = b;  m_alfsr = (b == '0) ? AW'(1) : b;
        m_pat   = p;  m_dlfsr = (p == '0) ? DW'(1) : p;
    endtask

    task automatic push_cmd(input logic is_wr);
        exp_t x;
        x.is_wr = is_wr;
        x.addr  = (m_amode == 2'b10) ? m_alfsr : m_base;
        x.data  = m_dmode ? m_dlfsr : m_pat;
        sb.push_back(x);
        if (m_amode == 2'b01) m_base = m_base + AW'(1);
        if (m_amode == 2'b10) m_alfsr = lfsr24_step(m_alfsr);
        if (is_wr && m_dmode) m_dlfsr = lfsr32_step(m_dlfsr);
    endtask

    task automatic scramble();
        addr_mode = 2'($urandom);
        data_mode = 1'($urandom);
        base_addr = AW'($urandom);
        pattern   = $urandom;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            acc_prev = 1'b0;
        end else begin
            check_eq("ready_timing", 32'(ready), 32'(acc_prev));
            if (ready) begin
                ready_cnt++;
                ready_cyc.push_back(cyc);
            end
            mon_acc = (wr || rd) && !waitreq;
            if (mon_acc) begin
                check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq("cmd_kind", 32'({wr, rd}), e.is_wr ? 32'd2 : 32'd1);
                    check_eq("address", 32'(address), 32'(e.addr));
                    if (e.is_wr) check_eq("writedata", wdata, e.data);
                end
            end
            acc_prev = mon_acc;
        end
    end

    task automatic wait_ready(input int n);
        int start;
        int k;
        start = ready_cnt;
        k = 0;
        while (ready_cnt < start + n && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        check_eq("ready_count", 32'(ready_cnt - start), 32'(n));
    endtask

    task automatic wait_strobe();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(wr || rd) && k < 20);
        check_eq("strobe_seen", 32'(wr | rd), 32'd1);
    endtask

    task automatic do_load(input logic [1:0] am, input logic dm, input logic [AW-1:0] b,
                           input logic [DW-1:0] p, input logic with_wr);
        @(posedge clk); #1;
        addr_mode = am; data_mode = dm; base_addr = b; pattern = p; load = 1'b1;
        model_load(am, dm, b, p);
        if (with_wr) begin
            push_cmd(1'b1);
            wr_en = 1'b1;
        end
        @(posedge clk); #1;
        load = 1'b0;
        scramble();
        if (with_wr) begin
            wait_ready(1);
            @(posedge clk); #1;
            wr_en = 1'b0;
        end
    endtask

    task automatic run_cmds(input logic is_wr, input int n, input logic both);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) push_cmd(is_wr);
        wr_en = is_wr || both;
        rd_en = !is_wr || both;
        wait_ready(n);
        @(posedge clk); #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] snap_a;
        logic [DW-1:0] snap_d;
        int            rc;

        rst = 1'b1; load = 1'b0; wr_en = 1'b0; rd_en = 1'b0; waitreq = 1'b0;
        addr_mode = 2'b00; data_mode = 1'b0; base_addr = '0; pattern = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_write", 32'(wr), 32'd0);
        check_eq("rst_read", 32'(rd), 32'd0);
        check_eq("rst_ready", 32'(ready), 32'd0);
        check_eq("rst_address", 32'(address), 32'd0);
        check_eq("rst_wdata", wdata, 32'd0);
        check_eq("byteenable", 32'(be), 32'hF);
        @(posedge clk); #1;
        rst = 1'b0;

        // incrementing address, fixed data, three back-to-back writes
        do_load(2'b01, 1'b0, 24'h000010, 32'hA5A5A5A5, 1'b0);
        ready_cyc.delete();
        run_cmds(1'b1, 3, 1'b0);
        check_eq("ready_pulses", 32'(ready_cyc.size()), 32'd3);
        if (ready_cyc.size() >= 3) begin
            check_eq("ready_gap1", 32'(ready_cyc[1] - ready_cyc[0]), 32'd3);
            check_eq("ready_gap2", 32'(ready_cyc[2] - ready_cyc[1]), 32'd3);
        end

        // write stalled by waitrequest for 5 cycles; request dropped mid-stall
        @(posedge clk); #1;
        waitreq = 1'b1;
        push_cmd(1'b1);
        wr_en = 1'b1;
        wait_strobe();
        snap_a = address;
        snap_d = wdata;
        for (int i = 1; i < 5; i++) begin
            @(posedge clk); #1;
            if (i == 2) wr_en = 1'b0;
            @(negedge clk);
            check_eq("stall_write", 32'(wr), 32'd1);
            check_eq("stall_addr", 32'(address), 32'(snap_a));
            check_eq("stall_data", wdata, snap_d);
        end
        @(posedge clk); #1;
        waitreq = 1'b0;
        @(negedge clk);
        check_eq("stall_write_last", 32'(wr), 32'd1);
        check_eq("stall_addr_last", 32'(address), 32'(snap_a));
        wait_ready(1);

        // incrementing wrap at the top of the address space
        do_load(2'b01, 1'b0, 24'hFFFFFF, 32'h0, 1'b0);
        run_cmds(1'b0, 2, 1'b0);

        // data LFSR with zero seed; reads must not advance data; reload repeats
        do_load(2'b00, 1'b1, 24'h000100, 32'h0, 1'b0);
        run_cmds(1'b1, 2, 1'b0);
        run_cmds(1'b0, 1, 1'b0);
        run_cmds(1'b1, 1, 1'b0);
        do_load(2'b00, 1'b1, 24'h000100, 32'h0, 1'b0);
        run_cmds(1'b1, 2, 1'b0);

        // write priority, then a load during WRITE is ignored
        do_load(2'b01, 1'b0, 24'h000200, 32'h12345678, 1'b0);
        run_cmds(1'b1, 1, 1'b1);
        @(posedge clk); #1;
        waitreq = 1'b1;
        push_cmd(1'b1);
        wr_en = 1'b1;
        @(posedge clk); #1;
        load = 1'b1; addr_mode = 2'b00; base_addr = 24'h000999; pattern = 32'hFFFF0000;
        @(posedge clk); #1;
        load = 1'b0; waitreq = 1'b0; wr_en = 1'b0;
        wait_ready(1);
        run_cmds(1'b1, 1, 1'b0);

        // load coinciding with a request in IDLE uses the new seeds
        do_load(2'b01, 1'b0, 24'h000300, 32'h0F0F0F0F, 1'b1);
        run_cmds(1'b0, 1, 1'b0);

        // random address mode, zero seed and a nonzero seed
        do_load(2'b10, 1'b0, 24'h000000, 32'hDEADBEEF, 1'b0);
        run_cmds(1'b1, 3, 1'b0);
        do_load(2'b10, 1'b1, 24'hABCDEF, 32'h80000001, 1'b0);
        run_cmds(1'b1, 2, 1'b0);
        run_cmds(1'b0, 2, 1'b0);

        // reserved address mode behaves as fixed
        do_load(2'b11, 1'b0, 24'h000055, 32'h00C0FFEE, 1'b0);
        run_cmds(1'b1, 2, 1'b0);

        // reset during a stalled read
        @(posedge clk); #1;
        waitreq = 1'b1;
        push_cmd(1'b0);
        rd_en = 1'b1;
        wait_strobe();
        #2 rst = 1'b1;
        #1;
        check_eq("arst_read", 32'(rd), 32'd0);
        check_eq("arst_write", 32'(wr), 32'd0);
        check_eq("arst_ready", 32'(ready), 32'd0);
        check_eq("arst_address", 32'(address), 32'd0);
        check_eq("arst_wdata", wdata, 32'd0);
        rd_en = 1'b0;
        waitreq = 1'b0;
        sb.delete();
        model_reset();
        rc = ready_cnt;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("no_ready_after_rst", 32'(ready_cnt - rc), 32'd0);
        run_cmds(1'b1, 2, 1'b0);

        repeat (3) @(negedge clk);
        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
